// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_pipe_reg.sv
// Output register stage holding {valid, pc, instr} for decode; clear beats load, otherwise holds.
module fetch_pipe_reg #(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [31:0]       i_instr,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_pc,
  output logic [31:0]       o_instr
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_instr;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_instr <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_instr <= i_instr;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_instr = r_instr;

endmodule

// File: rtl/fetch_sequencer.sv
// PC sequencer for a combinational instruction ROM with valid/ready output and branch redirects.
// Define FETCH_FAULT_EN to trap end-of-ROM and misaligned redirects; otherwise addresses wrap.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = 64,
  parameter int                IMEM_BYTES = 1024,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_instr,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [31:0]       out_instr,
  output logic [31:0]       instr_count,
  output logic              fetch_fault
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(INSTR_BYTES - 1);

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_count;

  logic              w_handshake, w_redirect, w_load_run, w_load, w_clear;
  logic              w_fault_tgt, w_fault_pc, w_go_fault;
  logic [ADDR_W-1:0] w_target, w_pc_inc;

  assign w_handshake = out_valid & out_ready;
  assign w_redirect  = redirect_valid & (r_state != FAULT);
  assign w_load_run  = (r_state == RUN) & (!out_valid | out_ready);

`ifdef FETCH_FAULT_EN
  logic r_fault;

  assign w_target    = redirect_target & ALIGN_MASK;
  assign w_pc_inc    = r_pc + ADDR_W'(INSTR_BYTES);
  assign w_fault_tgt = redirect_target[1:0] != 2'b00;
  assign w_fault_pc  = (r_pc + ADDR_W'(INSTR_BYTES - 1)) >= ADDR_W'(IMEM_BYTES);
  assign fetch_fault = r_fault;
`else
  localparam logic [ADDR_W-1:0] WRAP_MASK = ADDR_W'(IMEM_BYTES - 1);

  assign w_target    = redirect_target & ALIGN_MASK & WRAP_MASK;
  assign w_pc_inc    = (r_pc + ADDR_W'(INSTR_BYTES)) & WRAP_MASK;
  assign w_fault_tgt = 1'b0;
  assign w_fault_pc  = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  // A redirect outranks a load, so only its own target is checked when it is present.
  assign w_go_fault = w_redirect ? w_fault_tgt : (w_load_run & w_fault_pc);
  assign w_load     = w_load_run & !w_redirect & !w_fault_pc;
  assign w_clear    = w_redirect | w_go_fault;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc    <= RESET_PC;
      r_state <= RUN;
      r_count <= '0;
`ifdef FETCH_FAULT_EN
      r_fault <= 1'b0;
`endif
    end else begin
      // The handshake on a redirect edge is still a completed transfer.
      if (w_handshake && (r_count != '1)) r_count <= r_count + 32'd1;

      case (r_state)
        FAULT: ;
        default: begin
          if (w_go_fault) begin
            r_state <= FAULT;
`ifdef FETCH_FAULT_EN
            r_fault <= 1'b1;
`endif
          end else if (w_redirect) begin
            r_pc    <= w_target;
            r_state <= FLUSH;
          end else if (r_state == FLUSH) begin
            r_state <= RUN;
          end else if (w_load) begin
            r_pc <= w_pc_inc;
          end
        end
      endcase
    end
  end

  fetch_pipe_reg #(
    .ADDR_W (ADDR_W)
  ) u_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_load),
    .i_clear (w_clear),
    .i_pc    (r_pc),
    .i_instr (imem_instr),
    .o_valid (out_valid),
    .o_pc    (out_pc),
    .o_instr (out_instr)
  );

  assign imem_addr   = r_pc;
  assign instr_count = r_count;

endmodule
